// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock and releases core reset.
// Defining PLLSUP_FREQCHK_EN adds the freq_tgl window frequency check.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 5000,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned MAX_RETRY     = 7
`ifdef PLLSUP_FREQCHK_EN
  ,
  parameter int unsigned FREQ_WIN      = 1024,
  parameter int unsigned FREQ_MIN      = 78,
  parameter int unsigned FREQ_MAX      = 86
`endif
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
`ifdef PLLSUP_FREQCHK_EN
  input  logic       freq_tgl,
`endif
  output logic       pll_rst,
  output logic       sys_reset,
  output logic [3:0] retry_cnt,
  output logic       fail,
  output logic [2:0] state,
  output logic       freq_err
);

  localparam int unsigned CNT_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > RST_CYCLES) ? CNT_MAX0 : RST_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned GLT_W    = $clog2(GLITCH_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GLT_W-1:0]   glitch_q, glitch_d;
  logic [3:0]         retry_q, retry_d;
  logic [1:0]         lock_sync_q;
  logic               locked_s;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_q, sys_reset_d;
  logic               fail_q, fail_d;
  logic               win_bad_c;
  logic               freq_rearm_c;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked};
    end
  end

  assign locked_s = lock_sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      glitch_q    <= '0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      glitch_q    <= glitch_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    retry_d  = retry_q;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // lock seen on the timeout cycle takes priority over the retry
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RESET_PLL;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (win_bad_c) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          glitch_d = '0;
          retry_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if ((!locked_s && (glitch_q == GLT_W'(GLITCH_CYCLES - 1))) || freq_rearm_c) begin
          state_d  = ST_RESET_PLL;
          cnt_d    = '0;
          glitch_d = '0;
        end else if (!locked_s) begin
          glitch_d = glitch_q + GLT_W'(1);
        end else begin
          glitch_d = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    sys_reset_d = (state_d != ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

`ifdef PLLSUP_FREQCHK_EN
  localparam int unsigned WIN_W  = $clog2(FREQ_WIN);
  localparam int unsigned EDGE_W = $clog2(FREQ_WIN + 1);

  logic [2:0]        tgl_sync_q;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [EDGE_W-1:0] edges_q, edges_d, edges_tot;
  logic              bad_run_q, bad_run_d;
  logic              freq_err_q, freq_err_d;
  logic              tgl_edge, win_active, win_end;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_sync_q <= 3'b000;
      win_q      <= '0;
      edges_q    <= '0;
      bad_run_q  <= 1'b0;
      freq_err_q <= 1'b0;
    end else begin
      tgl_sync_q <= {tgl_sync_q[1:0], freq_tgl};
      win_q      <= win_d;
      edges_q    <= edges_d;
      bad_run_q  <= bad_run_d;
      freq_err_q <= freq_err_d;
    end
  end

  // Both toggle edges count; windows restart whenever the FSM changes state
  always_comb begin
    tgl_edge     = tgl_sync_q[2] ^ tgl_sync_q[1];
    win_active   = (state_q == ST_STABLE) || (state_q == ST_RUN);
    edges_tot    = edges_q + EDGE_W'(tgl_edge);
    win_end      = win_active && (win_q == WIN_W'(FREQ_WIN - 1));
    win_bad_c    = win_end && ((edges_tot < EDGE_W'(FREQ_MIN)) || (edges_tot > EDGE_W'(FREQ_MAX)));
    freq_rearm_c = win_bad_c && bad_run_q && (state_q == ST_RUN);
    freq_err_d   = win_end ? win_bad_c : freq_err_q;
    win_d        = win_q + WIN_W'(1);
    edges_d      = edges_tot;
    bad_run_d    = bad_run_q;
    if (!win_active || (state_d != state_q)) begin
      win_d     = '0;
      edges_d   = '0;
      bad_run_d = 1'b0;
    end else if (win_end) begin
      win_d     = '0;
      edges_d   = '0;
      bad_run_d = win_bad_c && (state_q == ST_RUN);
    end
  end

  assign freq_err = freq_err_q;
`else
  assign win_bad_c    = 1'b0;
  assign freq_rearm_c = 1'b0;
  assign freq_err     = 1'b0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign retry_cnt = retry_q;
  assign fail      = fail_q;
  assign state     = state_q;

endmodule
